pea_sequencer: RTL and testbench

Parametrised successor to the PE-array control FSM. Sequences one convolution job over cfg_num_pass passes: tag flush, ifmap/filter/psum loads, kernel flush, a counted compute window and a drain. Adds a filter-reuse mode, full-driven compute stall, a watchdog timeout, abort, and done/error reporting. Sits between the host/DMA register block and the PE array, buffers and tag logic.

---
 rtl/pea_ctrl_pkg.sv | 30 +++
 rtl/pea_watchdog.sv | 27 ++
 rtl/pea_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pea_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_ctrl_pkg.sv
// Shared types and constants for the PE-array job sequencer.
// The state encodings are also what state_dbg reports, so they are fixed explicitly.
package pea_ctrl_pkg;

  localparam int unsigned NUM_ROW_DEF = 7;
  localparam int unsigned NUM_COL_DEF = 7;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned PASS_W_DEF  = 8;
  localparam int unsigned TO_W_DEF    = 20;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned STATE_W     = 4;

  localparam logic [SEL_W-1:0] LOAD_SEL_IFMAP = 2'd0;
  localparam logic [SEL_W-1:0] LOAD_SEL_FLTR  = 2'd1;
  localparam logic [SEL_W-1:0] LOAD_SEL_PSUM  = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = 4'd0,
    ST_FLUSH_TAG    = 4'd1,
    ST_LOAD_IFMAP   = 4'd2,
    ST_LOAD_FLTR    = 4'd3,
    ST_LOAD_PSUM    = 4'd4,
    ST_FLUSH_KERNEL = 4'd5,
    ST_COMPUTE      = 4'd6,
    ST_DRAIN        = 4'd7,
    ST_DONE         = 4'd8,
    ST_ERROR        = 4'd9
  } state_t;

endpackage

// File: rtl/pea_watchdog.sv
// Per-state watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count reaches a nonzero limit.
module pea_watchdog #(
  parameter int unsigned TO_W = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count;

  // count holds the number of enabled cycles already completed in this state
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TO_W'(1);
    end
  end

  assign expired = enable && (limit != '0) && (count == limit - TO_W'(1));

endmodule

// File: rtl/pea_sequencer.sv
// Job sequencer for the PE array: tag flush, loads, kernel flush, counted
// compute with full-stall, drain, multi-pass with optional filter reuse.
module pea_sequencer import pea_ctrl_pkg::*; #(
  parameter int unsigned NUM_ROW = NUM_ROW_DEF,
  parameter int unsigned NUM_COL = NUM_COL_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PASS_W  = PASS_W_DEF,
  parameter int unsigned TO_W    = TO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PASS_W-1:0]  cfg_num_pass,
  input  logic               cfg_psum_en,
  input  logic               cfg_fltr_reuse,
  input  logic [CNT_W-1:0]   cfg_compute_cycles,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               ram_rst_busy,
  input  logic               tag_busy,
  input  logic [NUM_ROW-1:0] kernel_busy,
  input  logic [NUM_ROW-1:0] full,
  input  logic               load_done,
  output logic               load_req,
  output logic [SEL_W-1:0]   load_sel,
  output logic               flush_tag,
  output logic               flush_kernel,
  output logic               pe_start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [PASS_W-1:0]  pass_idx,
  output logic [STATE_W-1:0] state_dbg
);

  // NUM_COL only describes the array geometry; a zero-column array is unsupported.
  if (NUM_COL == 0) begin : g_num_col_invalid
  end

  state_t             state, next_state;
  logic [PASS_W-1:0]  num_pass_q;
  logic               psum_en_q, reuse_q;
  logic [CNT_W-1:0]   cycles_q, cmp_cnt;
  logic [TO_W-1:0]    timeout_q;
  logic               dwell_ok, state_chg, job_start, last_pass;
  logic               wd_enable, wd_expired;
  logic               load_req_d, flush_tag_d, flush_kernel_d, pe_start_d;
  logic               busy_d, done_d, error_d;
  logic [SEL_W-1:0]   load_sel_d;

  assign state_chg = (next_state != state);
  assign job_start = (state == ST_IDLE) && (next_state == ST_FLUSH_TAG);
  assign last_pass = (pass_idx == num_pass_q - PASS_W'(1));

  // Next state plus the next value of every registered output
  always_comb begin
    next_state     = state;
    load_req_d     = 1'b0;
    load_sel_d     = LOAD_SEL_IFMAP;
    flush_tag_d    = 1'b0;
    flush_kernel_d = 1'b0;
    pe_start_d     = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    error_d        = 1'b0;

    if (abort) begin
      next_state = ST_IDLE;
    end else if (ram_rst_busy && (state != ST_IDLE) && (state != ST_ERROR)) begin
      next_state = ST_ERROR;
    end else if (wd_expired) begin
      next_state = ST_ERROR;
    end else begin
      case (state)
        ST_IDLE:         if (start && !ram_rst_busy) next_state = ST_FLUSH_TAG;
        ST_FLUSH_TAG:    if (dwell_ok && !tag_busy) next_state = ST_LOAD_IFMAP;
        ST_LOAD_IFMAP: begin
          if (load_done) begin
            if ((pass_idx != '0) && reuse_q)
              next_state = psum_en_q ? ST_LOAD_PSUM : ST_FLUSH_KERNEL;
            else
              next_state = ST_LOAD_FLTR;
          end
        end
        ST_LOAD_FLTR:    if (load_done) next_state = psum_en_q ? ST_LOAD_PSUM : ST_FLUSH_KERNEL;
        ST_LOAD_PSUM:    if (load_done) next_state = ST_FLUSH_KERNEL;
        ST_FLUSH_KERNEL: if (dwell_ok && !(|kernel_busy)) next_state = ST_COMPUTE;
        ST_COMPUTE:      if (pe_start && (cmp_cnt == CNT_W'(1))) next_state = ST_DRAIN;
        ST_DRAIN:        if (!(|kernel_busy)) next_state = last_pass ? ST_DONE : ST_LOAD_IFMAP;
        ST_DONE:         next_state = ST_IDLE;
        ST_ERROR:        next_state = ST_ERROR;
        default:         next_state = ST_IDLE;
      endcase
    end

    load_req_d     = next_state inside {ST_LOAD_IFMAP, ST_LOAD_FLTR, ST_LOAD_PSUM};
    flush_tag_d    = (next_state == ST_FLUSH_TAG);
    flush_kernel_d = (next_state == ST_FLUSH_KERNEL);
    pe_start_d     = (next_state == ST_COMPUTE) && !(|full);
    busy_d         = (next_state != ST_IDLE);
    done_d         = (next_state == ST_DONE);
    error_d        = (next_state == ST_ERROR);
    if (next_state == ST_LOAD_FLTR) load_sel_d = LOAD_SEL_FLTR;
    if (next_state == ST_LOAD_PSUM) load_sel_d = LOAD_SEL_PSUM;
  end

  // Watchdog counts waiting states and full-stalled compute cycles
  always_comb begin
    wd_enable = 1'b0;
    case (state)
      ST_FLUSH_TAG, ST_LOAD_IFMAP, ST_LOAD_FLTR, ST_LOAD_PSUM,
      ST_FLUSH_KERNEL, ST_DRAIN: wd_enable = 1'b1;
      ST_COMPUTE:                wd_enable = !pe_start;
      default:                   wd_enable = 1'b0;
    endcase
  end

  pea_watchdog #(.TO_W(TO_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg),
    .enable  (wd_enable),
    .limit   (timeout_q),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      load_req     <= 1'b0;
      load_sel     <= LOAD_SEL_IFMAP;
      flush_tag    <= 1'b0;
      flush_kernel <= 1'b0;
      pe_start     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      state_dbg    <= '0;
    end else begin
      state        <= next_state;
      load_req     <= load_req_d;
      load_sel     <= load_sel_d;
      flush_tag    <= flush_tag_d;
      flush_kernel <= flush_kernel_d;
      pe_start     <= pe_start_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      state_dbg    <= next_state;
    end
  end

  // Job configuration is captured on start and held for the whole job
  always_ff @(posedge clk) begin
    if (rst) begin
      num_pass_q <= PASS_W'(1);
      psum_en_q  <= 1'b0;
      reuse_q    <= 1'b0;
      cycles_q   <= CNT_W'(1);
      timeout_q  <= '0;
      pass_idx   <= '0;
    end else if (job_start) begin
      num_pass_q <= (cfg_num_pass == '0) ? PASS_W'(1) : cfg_num_pass;
      psum_en_q  <= cfg_psum_en;
      reuse_q    <= cfg_fltr_reuse;
      cycles_q   <= (cfg_compute_cycles == '0) ? CNT_W'(1) : cfg_compute_cycles;
      timeout_q  <= cfg_timeout;
      pass_idx   <= '0;
    end else if ((state == ST_DRAIN) && (next_state == ST_LOAD_IFMAP)) begin
      pass_idx   <= pass_idx + PASS_W'(1);
    end
  end

  // dwell_ok is low only on the first cycle of each state
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_ok <= 1'b0;
      cmp_cnt  <= '0;
    end else begin
      dwell_ok <= !state_chg;
      if ((state != ST_COMPUTE) && (next_state == ST_COMPUTE))
        cmp_cnt <= cycles_q;
      else if ((state == ST_COMPUTE) && pe_start)
        cmp_cnt <= cmp_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pea_sequencer.sv
// Directed bench for pea_sequencer: scenario tasks with hand-computed
// state traces, pulse counts and output values.
module tb_pea_sequencer;

  localparam int unsigned NR = 7;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;
  localparam int unsigned TW = 20;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [PW-1:0] cfg_num_pass;
  logic          cfg_psum_en, cfg_fltr_reuse;
  logic [CW-1:0] cfg_compute_cycles;
  logic [TW-1:0] cfg_timeout;
  logic          ram_rst_busy, tag_busy, load_done;
  logic [NR-1:0] kernel_busy, full;
  logic          load_req, flush_tag, flush_kernel, pe_start, busy, done, error;
  logic [1:0]    load_sel;
  logic [PW-1:0] pass_idx;
  logic [3:0]    state_dbg;

  pea_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_pass(cfg_num_pass), .cfg_psum_en(cfg_psum_en),
    .cfg_fltr_reuse(cfg_fltr_reuse), .cfg_compute_cycles(cfg_compute_cycles),
    .cfg_timeout(cfg_timeout), .ram_rst_busy(ram_rst_busy), .tag_busy(tag_busy),
    .kernel_busy(kernel_busy), .full(full), .load_done(load_done),
    .load_req(load_req), .load_sel(load_sel), .flush_tag(flush_tag),
    .flush_kernel(flush_kernel), .pe_start(pe_start), .busy(busy), .done(done),
    .error(error), .pass_idx(pass_idx), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int trace[$];
  int pidx_log[$];
  int n_pe, n_done, n_comp, n_stall, last_st, lr_cnt;
  bit auto_load;
  bit busy_at_done;
  logic prev_flush_tag;

  // One clock: observe #1 after the edge, update monitors and host/buffer responders
  task automatic step();
    @(posedge clk);
    #1;
    if (pe_start) n_pe++;
    if (done) begin n_done++; busy_at_done = busy; end
    if (int'(state_dbg) == 6) begin
      n_comp++;
      if (!pe_start) n_stall++;
    end
    if (int'(state_dbg) != last_st) begin
      trace.push_back(int'(state_dbg));
      if (int'(state_dbg) == 6) pidx_log.push_back(int'(pass_idx));
      last_st = int'(state_dbg);
    end
    tag_busy = flush_tag && !prev_flush_tag;
    prev_flush_tag = flush_tag;
    if (auto_load && load_req) begin
      if (lr_cnt == 2) begin load_done = 1'b1; lr_cnt = 0; end
      else begin load_done = 1'b0; lr_cnt++; end
    end else begin
      load_done = 1'b0;
      lr_cnt = 0;
    end
  endtask

  task automatic clr_mon();
    trace.delete();
    pidx_log.delete();
    n_pe = 0; n_done = 0; n_comp = 0; n_stall = 0;
    busy_at_done = 1'b0;
    last_st = int'(state_dbg);
  endtask

  // Pulse start and run until the sequencer is back in IDLE or ERROR
  task automatic run_job(output bit ok);
    clr_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (int'(state_dbg) == 0 || int'(state_dbg) == 9) break;
      step();
    end
    ok = (int'(state_dbg) == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    checks++; if (int'(state_dbg) !== 0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    checks++; if ({load_req, flush_tag, flush_kernel, pe_start, busy, done, error} !== 7'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000000", {load_req, flush_tag, flush_kernel, pe_start, busy, done, error});
    end
    checks++; if (pass_idx !== '0 || load_sel !== 2'd0) begin
      failures++; $display("FAIL reset_pass_sel got=%0d/%0d exp=0/0", pass_idx, load_sel);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    int exp_tr[$] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
    cfg_num_pass = 8'd1; cfg_psum_en = 1'b1; cfg_fltr_reuse = 1'b0;
    cfg_compute_cycles = 16'd4; cfg_timeout = '0;
    run_job(ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_finish got_state=%0d exp=0", state_dbg); end
    checks++; if (trace.size() !== exp_tr.size()) begin failures++; $display("FAIL basic_trace_len got=%0d exp=%0d", trace.size(), exp_tr.size()); end
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++) begin
      checks++; if (trace[i] !== exp_tr[i]) begin failures++; $display("FAIL basic_trace[%0d] got=%0d exp=%0d", i, trace[i], exp_tr[i]); end
    end
    checks++; if (n_pe !== 4 || n_comp !== 4) begin failures++; $display("FAIL basic_pe_start got=%0d/%0d exp=4/4", n_pe, n_comp); end
    checks++; if (n_done !== 1 || busy_at_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0d busy=%0b exp=1 busy=1", n_done, busy_at_done); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_idle got busy=%0b done=%0b exp=0/0", busy, done); end
  endtask

  task automatic test_multipass_reuse();
    bit ok;
    int exp_tr[$] = '{1, 2, 3, 5, 6, 7, 2, 5, 6, 7, 2, 5, 6, 7, 8, 0};
    int exp_pi[$] = '{0, 1, 2};
    cfg_num_pass = 8'd3; cfg_psum_en = 1'b0; cfg_fltr_reuse = 1'b1;
    cfg_compute_cycles = 16'd2; cfg_timeout = '0;
    clr_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    // later cfg changes must not affect the running job
    cfg_num_pass = 8'd1; cfg_fltr_reuse = 1'b0; cfg_compute_cycles = 16'd9;
    for (int i = 0; i < 400; i++) begin
      if (int'(state_dbg) == 0 || int'(state_dbg) == 9) break;
      step();
    end
    ok = (int'(state_dbg) == 0);
    checks++; if (!ok) begin failures++; $display("FAIL multi_finish got_state=%0d exp=0", state_dbg); end
    checks++; if (trace.size() !== exp_tr.size()) begin failures++; $display("FAIL multi_trace_len got=%0d exp=%0d", trace.size(), exp_tr.size()); end
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++) begin
      checks++; if (trace[i] !== exp_tr[i]) begin failures++; $display("FAIL multi_trace[%0d] got=%0d exp=%0d", i, trace[i], exp_tr[i]); end
    end
    checks++; if (pidx_log.size() !== 3) begin failures++; $display("FAIL multi_windows got=%0d exp=3", pidx_log.size()); end
    for (int i = 0; i < 3 && i < pidx_log.size(); i++) begin
      checks++; if (pidx_log[i] !== exp_pi[i]) begin failures++; $display("FAIL multi_pass_idx[%0d] got=%0d exp=%0d", i, pidx_log[i], exp_pi[i]); end
    end
    checks++; if (n_comp !== 6 || n_done !== 1) begin failures++; $display("FAIL multi_counts got comp=%0d done=%0d exp=6/1", n_comp, n_done); end
    checks++; if (int'(pass_idx) !== 2) begin failures++; $display("FAIL multi_pass_hold got=%0d exp=2", pass_idx); end
  endtask

  task automatic test_stall();
    int hold;
    bit fired;
    int exp_tr[$] = '{1, 2, 3, 5, 6, 7, 8, 0};
    cfg_num_pass = 8'd1; cfg_psum_en = 1'b0; cfg_fltr_reuse = 1'b0;
    cfg_compute_cycles = 16'd5; cfg_timeout = '0;
    hold = 0; fired = 1'b0;
    clr_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (int'(state_dbg) == 0 || int'(state_dbg) == 9) break;
      step();
      if (hold > 0) begin
        hold--;
        if (hold == 0) full = '0;
      end
      if (int'(state_dbg) == 6 && n_comp == 2 && !fired) begin
        full = 7'b0000100;
        hold = 3;
        fired = 1'b1;
      end
    end
    full = '0;
    checks++; if (int'(state_dbg) !== 0) begin failures++; $display("FAIL stall_finish got_state=%0d exp=0", state_dbg); end
    checks++; if (n_comp !== 8) begin failures++; $display("FAIL stall_compute_len got=%0d exp=8", n_comp); end
    checks++; if (n_pe !== 5 || n_stall !== 3) begin failures++; $display("FAIL stall_pe_start got high=%0d low=%0d exp=5/3", n_pe, n_stall); end
    checks++; if (trace.size() !== exp_tr.size()) begin failures++; $display("FAIL stall_trace_len got=%0d exp=%0d", trace.size(), exp_tr.size()); end
  endtask

  task automatic test_timeout();
    int i;
    cfg_num_pass = 8'd1; cfg_psum_en = 1'b0; cfg_fltr_reuse = 1'b0;
    cfg_compute_cycles = 16'd1; cfg_timeout = 20'd10;
    auto_load = 1'b0;
    clr_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (i = 0; i < 20 && int'(state_dbg) != 2; i++) step();
    checks++; if (int'(state_dbg) !== 2) begin failures++; $display("FAIL timeout_reach_load got_state=%0d exp=2", state_dbg); end
    repeat (9) step();
    checks++; if (int'(state_dbg) !== 2) begin failures++; $display("FAIL timeout_early got_state=%0d exp=2", state_dbg); end
    step();
    checks++; if (int'(state_dbg) !== 9) begin failures++; $display("FAIL timeout_error_state got=%0d exp=9", state_dbg); end
    checks++; if (error !== 1'b1 || load_req !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_error_outputs got err=%0b req=%0b busy=%0b exp=1/0/1", error, load_req, busy);
    end
    step();
    checks++; if (int'(state_dbg) !== 9 || error !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%0d err=%0b exp=9/1", state_dbg, error); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (int'(state_dbg) !== 0 || error !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_abort got=%0d err=%0b busy=%0b exp=0/0/0", state_dbg, error, busy);
    end
    auto_load = 1'b1;
    cfg_timeout = '0;
    step();
  endtask

  task automatic test_collision();
    cfg_num_pass = 8'd1; cfg_psum_en = 1'b0; cfg_fltr_reuse = 1'b0;
    cfg_compute_cycles = 16'd3; cfg_timeout = '0;
    clr_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && int'(state_dbg) != 5; i++) step();
    checks++; if (int'(state_dbg) !== 5) begin failures++; $display("FAIL collide_reach_fk got_state=%0d exp=5", state_dbg); end
    ram_rst_busy = 1'b1;
    step();
    checks++; if (int'(state_dbg) !== 9 || error !== 1'b1 || flush_kernel !== 1'b0) begin
      failures++; $display("FAIL collide_error got=%0d err=%0b fk=%0b exp=9/1/0", state_dbg, error, flush_kernel);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (int'(state_dbg) !== 0) begin failures++; $display("FAIL collide_abort got=%0d exp=0", state_dbg); end
    start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    checks++; if (int'(state_dbg) !== 0 || busy !== 1'b0 || flush_tag !== 1'b0) begin
      failures++; $display("FAIL collide_start_blocked got=%0d busy=%0b ft=%0b exp=0/0/0", state_dbg, busy, flush_tag);
    end
    ram_rst_busy = 1'b0;
    step();
  endtask

  task automatic test_priority();
    bit ok;
    int exp_tr[$] = '{1, 2, 3, 5, 6, 7, 8, 0};
    cfg_num_pass = 8'd0; cfg_psum_en = 1'b0; cfg_fltr_reuse = 1'b0;
    cfg_compute_cycles = 16'd0; cfg_timeout = '0;
    run_job(ok);
    checks++; if (!ok || trace.size() !== exp_tr.size()) begin failures++; $display("FAIL zero_cfg_trace got len=%0d exp=%0d", trace.size(), exp_tr.size()); end
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++) begin
      checks++; if (trace[i] !== exp_tr[i]) begin failures++; $display("FAIL zero_cfg_trace[%0d] got=%0d exp=%0d", i, trace[i], exp_tr[i]); end
    end
    checks++; if (n_pe !== 1 || n_comp !== 1 || n_done !== 1) begin
      failures++; $display("FAIL zero_cfg_counts got pe=%0d comp=%0d done=%0d exp=1/1/1", n_pe, n_comp, n_done);
    end
    cfg_num_pass = 8'd2; cfg_compute_cycles = 16'd3;
    clr_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && !(int'(state_dbg) == 6 && int'(pass_idx) == 1); i++) step();
    checks++; if (int'(state_dbg) !== 6 || int'(pass_idx) !== 1) begin
      failures++; $display("FAIL prio_reach_compute got=%0d pass=%0d exp=6/1", state_dbg, pass_idx);
    end
    rst = 1'b1; abort = 1'b1;
    step();
    checks++; if ({load_req, flush_tag, flush_kernel, pe_start, busy, done, error} !== 7'b0 || int'(state_dbg) !== 0) begin
      failures++; $display("FAIL prio_outputs got=%b state=%0d exp=0000000/0", {load_req, flush_tag, flush_kernel, pe_start, busy, done, error}, state_dbg);
    end
    checks++; if (pass_idx !== '0) begin failures++; $display("FAIL prio_pass_idx got=%0d exp=0", pass_idx); end
    rst = 1'b0; abort = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_num_pass = '0; cfg_psum_en = 1'b0; cfg_fltr_reuse = 1'b0;
    cfg_compute_cycles = '0; cfg_timeout = '0;
    ram_rst_busy = 1'b0; tag_busy = 1'b0; load_done = 1'b0;
    kernel_busy = '0; full = '0;
    auto_load = 1'b1; prev_flush_tag = 1'b0; lr_cnt = 0; last_st = 0;
    n_pe = 0; n_done = 0; n_comp = 0; n_stall = 0; busy_at_done = 1'b0;
    test_reset();
    test_basic();
    test_multipass_reuse();
    test_stall();
    test_timeout();
    test_collision();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
